// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner with scan-level debounce, NUM_DIGITS-nibble hex entry buffer
// (backspace/submit), and a time-multiplexed seven-segment digit driver.
module keypad_entry_scanner #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned REFRESH_DIV    = 100000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [3:0]                        row,
   output logic [3:0]                        col,
   input  logic                              btn_back,
   input  logic                              btn_submit,
   output logic [NUM_DIGITS-1:0]             an,
   output logic [3:0]                        hex_out,
   output logic                              blank,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
   output logic [4*NUM_DIGITS-1:0]           guess,
   output logic                              guess_valid
);

   localparam int unsigned CW  = $clog2(NUM_DIGITS + 1);
   localparam int unsigned DW  = $clog2(NUM_DIGITS);
   localparam int unsigned EW  = 4 * NUM_DIGITS;
   localparam int unsigned SDW = $clog2(SCAN_DIV + 1);
   localparam int unsigned RDW = $clog2(REFRESH_DIV + 1);
   localparam int unsigned DBW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_HELD, ST_REL} deb_state_t;

   function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
      case ({c, r})
         4'b00_00: key_map = 4'h1;
         4'b00_01: key_map = 4'h4;
         4'b00_10: key_map = 4'h7;
         4'b00_11: key_map = 4'h0;
         4'b01_00: key_map = 4'h2;
         4'b01_01: key_map = 4'h5;
         4'b01_10: key_map = 4'h8;
         4'b01_11: key_map = 4'hF;
         4'b10_00: key_map = 4'h3;
         4'b10_01: key_map = 4'h6;
         4'b10_10: key_map = 4'h9;
         4'b10_11: key_map = 4'hE;
         4'b11_00: key_map = 4'hA;
         4'b11_01: key_map = 4'hB;
         4'b11_10: key_map = 4'hC;
         default:  key_map = 4'hD;
      endcase
   endfunction

   logic [SDW-1:0] scan_cnt;
   logic [1:0]     col_idx;
   logic [3:0]     row_s1, row_s2;
   logic           scan_found;
   logic [3:0]     scan_code;
   logic           col_last, scan_done, row_hit, key_found_c;
   logic [1:0]     row_idx;
   logic [3:0]     code_c, code_now;

   assign col_last    = (scan_cnt == SDW'(SCAN_DIV - 1));
   assign scan_done   = col_last && (col_idx == 2'd3);
   assign row_hit     = (row_s2 != 4'hF);
   assign code_c      = key_map(col_idx, row_idx);
   assign key_found_c = scan_found || row_hit;
   assign code_now    = scan_found ? scan_code : code_c;

   // lowest-numbered low row wins
   always_comb begin
      row_idx = 2'd3;
      casez (row_s2)
         4'b???0: row_idx = 2'd0;
         4'b??01: row_idx = 2'd1;
         4'b?011: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
   end

   // column drive, row synchronizer and first-key-per-scan capture
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt   <= '0;
         col_idx    <= 2'd0;
         col        <= 4'b1110;
         row_s1     <= 4'hF;
         row_s2     <= 4'hF;
         scan_found <= 1'b0;
         scan_code  <= 4'h0;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
         if (col_last) begin
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col      <= ~(4'b0001 << 2'(col_idx + 2'd1));
            if (col_idx == 2'd3) begin
               scan_found <= 1'b0;
            end else if (!scan_found && row_hit) begin
               scan_found <= 1'b1;
               scan_code  <= code_c;
            end
         end else begin
            scan_cnt <= scan_cnt + SDW'(1);
         end
      end
   end

   deb_state_t     state, state_next;
   logic [DBW-1:0] deb_cnt, deb_cnt_next;
   logic [3:0]     cand_code, cand_code_next;
   logic           press_c;
   logic [3:0]     press_code_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         deb_cnt   <= '0;
         cand_code <= 4'h0;
      end else begin
         state     <= state_next;
         deb_cnt   <= deb_cnt_next;
         cand_code <= cand_code_next;
      end
   end

   // debounce decision, taken once per completed four-column scan
   always_comb begin
      state_next     = state;
      deb_cnt_next   = deb_cnt;
      cand_code_next = cand_code;
      press_c        = 1'b0;
      press_code_c   = cand_code;
      if (scan_done) begin
         case (state)
            ST_IDLE: begin
               if (key_found_c) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     press_c      = 1'b1;
                     press_code_c = code_now;
                     state_next   = ST_HELD;
                  end else begin
                     state_next     = ST_CAND;
                     deb_cnt_next   = DBW'(1);
                     cand_code_next = code_now;
                  end
               end
            end
            ST_CAND: begin
               if (!key_found_c) begin
                  state_next = ST_IDLE;
               end else if (code_now != cand_code) begin
                  cand_code_next = code_now;
                  deb_cnt_next   = DBW'(1);
               end else if (deb_cnt + DBW'(1) == DBW'(DEBOUNCE_SCANS)) begin
                  press_c    = 1'b1;
                  state_next = ST_HELD;
               end else begin
                  deb_cnt_next = deb_cnt + DBW'(1);
               end
            end
            ST_HELD: begin
               if (!key_found_c) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_next = ST_IDLE;
                  end else begin
                     state_next   = ST_REL;
                     deb_cnt_next = DBW'(1);
                  end
               end
            end
            default: begin
               if (key_found_c) begin
                  state_next = ST_HELD;
               end else if (deb_cnt + DBW'(1) == DBW'(DEBOUNCE_SCANS)) begin
                  state_next = ST_IDLE;
               end else begin
                  deb_cnt_next = deb_cnt + DBW'(1);
               end
            end
         endcase
      end
   end

   logic [EW-1:0] entry;
   logic          back_q, submit_q, back_edge, submit_edge;

   assign back_edge   = btn_back && !back_q;
   assign submit_edge = btn_submit && !submit_q;

   // entry buffer: submit beats back beats press; losers are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         back_q      <= 1'b0;
         submit_q    <= 1'b0;
         entry       <= '0;
         count       <= '0;
         guess       <= '0;
         guess_valid <= 1'b0;
      end else begin
         back_q      <= btn_back;
         submit_q    <= btn_submit;
         guess_valid <= 1'b0;
         if (submit_edge) begin
            if (count == CW'(NUM_DIGITS)) begin
               guess       <= entry;
               guess_valid <= 1'b1;
               entry       <= '0;
               count       <= '0;
            end
         end else if (back_edge) begin
            if (count != '0) begin
               entry <= {4'h0, entry[EW-1:4]};
               count <= count - CW'(1);
            end
         end else if (press_c) begin
            if (count < CW'(NUM_DIGITS)) begin
               entry <= {entry[EW-5:0], press_code_c};
               count <= count + CW'(1);
            end
         end
      end
   end

   logic [RDW-1:0] ref_cnt;
   logic [DW-1:0]  dig;

   // digit refresh; anode and its data are registered from the same index
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt <= '0;
         dig     <= '0;
         an      <= ~NUM_DIGITS'(1);
         hex_out <= 4'h0;
         blank   <= 1'b1;
      end else begin
         if (ref_cnt == RDW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            dig     <= (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + DW'(1);
         end else begin
            ref_cnt <= ref_cnt + RDW'(1);
         end
         an      <= ~(NUM_DIGITS'(1) << dig);
         hex_out <= entry[{dig, 2'b00} +: 4];
         blank   <= (CW'(dig) >= count);
      end
   end

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner: keypad model, entry/display checks,
// and a guess scoreboard drained by an independent guess_valid monitor.
module tb_keypad_entry_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row, col;
   logic        btn_back, btn_submit;
   logic [3:0]  an;
   logic [3:0]  hex_out;
   logic        blank;
   logic [2:0]  count;
   logic [15:0] guess;
   logic        guess_valid;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   logic       key_on = 1'b0;
   logic [1:0] key_col = 2'd0;
   logic [1:0] key_row = 2'd0;

   always #5 clk = ~clk;

   assign row = (key_on && (col[key_col] == 1'b0)) ? ~(4'b0001 << key_row) : 4'b1111;

   keypad_entry_scanner #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REFRESH_DIV(8)
   ) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .btn_back(btn_back), .btn_submit(btn_submit),
      .an(an), .hex_out(hex_out), .blank(blank), .count(count),
      .guess(guess), .guess_valid(guess_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // key code -> (column, row) on the keypad
   task automatic key_pos(input logic [3:0] code, output logic [1:0] c, output logic [1:0] r);
      case (code)
         4'h1: begin c = 2'd0; r = 2'd0; end
         4'h4: begin c = 2'd0; r = 2'd1; end
         4'h7: begin c = 2'd0; r = 2'd2; end
         4'h0: begin c = 2'd0; r = 2'd3; end
         4'h2: begin c = 2'd1; r = 2'd0; end
         4'h5: begin c = 2'd1; r = 2'd1; end
         4'h8: begin c = 2'd1; r = 2'd2; end
         4'hF: begin c = 2'd1; r = 2'd3; end
         4'h3: begin c = 2'd2; r = 2'd0; end
         4'h6: begin c = 2'd2; r = 2'd1; end
         4'h9: begin c = 2'd2; r = 2'd2; end
         4'hE: begin c = 2'd2; r = 2'd3; end
         4'hA: begin c = 2'd3; r = 2'd0; end
         4'hB: begin c = 2'd3; r = 2'd1; end
         4'hC: begin c = 2'd3; r = 2'd2; end
         default: begin c = 2'd3; r = 2'd3; end
      endcase
   endtask

   task automatic hold_key(input logic [3:0] code, input int cycles);
      logic [1:0] c, r;
      key_pos(code, c, r);
      key_col = c;
      key_row = r;
      key_on  = 1'b1;
      tick(cycles);
      key_on  = 1'b0;
   endtask

   task automatic press(input logic [3:0] code);
      hold_key(code, 64);
      tick(64);
   endtask

   task automatic pulse_back();
      btn_back = 1'b1;
      tick(2);
      btn_back = 1'b0;
      tick(2);
   endtask

   task automatic pulse_submit();
      btn_submit = 1'b1;
      tick(2);
      btn_submit = 1'b0;
      tick(2);
   endtask

   // reconstruct the entry from the multiplexed display
   task automatic check_entry(input string name, input logic [15:0] exp);
      logic [15:0] v = 16'h0;
      logic [3:0]  seen = 4'h0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (an == ~(4'b0001 << i)) begin
               v[i*4 +: 4] = hex_out;
               seen[i]     = 1'b1;
            end
         end
      end
      check({name, "_digits_seen"}, 32'(seen), 32'hF);
      check(name, 32'(v), 32'(exp));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"}, 32'(col), 32'hE);
      check({tag, "_an"}, 32'(an), 32'hE);
      check({tag, "_hex"}, 32'(hex_out), 32'h0);
      check({tag, "_blank"}, 32'(blank), 32'h1);
      check({tag, "_count"}, 32'(count), 32'h0);
      check({tag, "_guess"}, 32'(guess), 32'h0);
      check({tag, "_gv"}, 32'(guess_valid), 32'h0);
   endtask

   // scoreboard monitor: every guess_valid pulse must match a queued guess
   initial begin
      logic prev_gv = 1'b0;
      forever begin
         @(negedge clk);
         if (guess_valid) begin
            check("gv_one_cycle", 32'(prev_gv), 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_guess: got %0h expected no pulse", guess);
            end else begin
               check("guess", 32'(guess), 32'(exp_q.pop_front()));
            end
         end
         prev_gv = guess_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] exp_hex[4]  = '{4'h9, 4'hA, 4'h0, 4'h0};
      logic       exp_blk[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] prev_col;
      logic [3:0] prev_an;
      bit         found;
      int         d, pd;

      rst = 1'b1;
      btn_back = 1'b0;
      btn_submit = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(2);

      // single-scan glitch must not register
      hold_key(4'h6, 16);
      tick(64);
      check("glitch_count", 32'(count), 32'h0);

      press(4'h2);
      check("press2_count", 32'(count), 32'h1);
      check_entry("press2_entry", 16'h0002);
      pulse_back();
      check("clear_count", 32'(count), 32'h0);

      // fill, overflow, submit
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
      check("full_count", 32'(count), 32'h4);
      check_entry("full_entry", 16'h1234);
      exp_q.push_back(16'h1234);
      pulse_submit();
      check("after_submit_count", 32'(count), 32'h0);
      check("after_submit_guess", 32'(guess), 32'h1234);
      check_entry("after_submit_entry", 16'h0000);

      // backspace
      press(4'h7); press(4'h8);
      pulse_back();
      check("back1_count", 32'(count), 32'h1);
      check_entry("back1_entry", 16'h0007);
      pulse_back();
      pulse_back();
      check("back3_count", 32'(count), 32'h0);
      check_entry("back3_entry", 16'h0000);

      // early submit is a no-op
      press(4'h1); press(4'h2); press(4'h3);
      pulse_submit();
      check("early_submit_count", 32'(count), 32'h3);

      // align to a scan boundary so the press lands on a known edge
      found = 1'b0;
      prev_col = col;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (col == 4'b1110 && prev_col == 4'b0111) found = 1'b1;
         prev_col = col;
      end
      check("scan_align", 32'(found), 32'h1);
      key_col = 2'd0;
      key_row = 2'd1;
      key_on  = 1'b1;
      tick(31);
      btn_back = 1'b1;
      tick(1);
      btn_back = 1'b0;
      tick(32);
      key_on = 1'b0;
      tick(64);
      check("priority_count", 32'(count), 32'h2);
      check_entry("priority_entry", 16'h0012);

      // display mux
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      press(4'hA); press(4'h9);
      check("disp_count", 32'(count), 32'h2);
      prev_an = an;
      pd = -1;
      for (int t = 0; t < 32; t++) begin
         @(negedge clk);
         d = -1;
         for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) d = i;
         if (d < 0) begin
            check("disp_an_onehot", 32'(an), 32'hE);
         end else begin
            check("disp_hex", 32'(hex_out), 32'(exp_hex[d]));
            check("disp_blank", 32'(blank), 32'(exp_blk[d]));
            if (pd >= 0 && d != pd) check("disp_an_step", 32'(d), 32'((pd + 1) % 4));
            pd = d;
         end
      end
      rst = 1'b1;
      tick(1);
      check_reset_outputs("midreset");
      rst = 1'b0;
      tick(4);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_entry_scanner.md
Name: keypad_entry_scanner

Overview:
- Parametrised successor to the keypad/seven-segment path: scans a 4x4 keypad, debounces key presses into single events, and assembles an NUM_DIGITS-digit hex entry with backspace and submit.
- Time-multiplexes the entry onto the seven-segment anodes.
- Sits between the keypad port and the hex-to-segment decoder; feeds the game logic a latched guess.

Parameters:
- NUM_DIGITS, 4, entry length and anode count (2..8)
- SCAN_DIV, 100000, clk cycles each keypad column is driven
- DEBOUNCE_SCANS, 4, consecutive full scans a key state must persist (>=1)
- REFRESH_DIV, 100000, clk cycles each display digit is lit

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row  in  4  keypad rows, active low (pulled up)
- col  out  4  keypad column drive, one-hot active low
- btn_back  in  1  backspace button, debounced level
- btn_submit  in  1  submit button, debounced level
- an  out  NUM_DIGITS  anodes, one-hot active low
- hex_out  out  4  nibble for the currently lit digit
- blank  out  1  high when the lit digit holds no entry
- count  out  $clog2(NUM_DIGITS+1)  digits currently entered
- guess  out  4*NUM_DIGITS  last submitted entry
- guess_valid  out  1  one-cycle pulse when guess updates

Behaviour:
- Reset values:
  - col=4'b1110
  - an: bit0 low, all others high
  - hex_out=0, blank=1, count=0, guess=0, guess_valid=0
  - entry buffer cleared; debounce FSM in IDLE
  - Reset mid-scan or mid-entry discards everything; no guess_valid is produced.
- Scan:
  - Column index c cycles 0,1,2,3,0,… and advances every SCAN_DIV cycles.
  - col = ~(1<<c).
  - Rows are sampled on the last cycle of each column dwell, through a 2-flop synchronizer.
- Key map (col,row) -> code:
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
  - Lowest-numbered low row wins. The first pressed key found in a scan, in column order, is that scan's key. "None" if no row is low in any column.
- Debounce FSM, evaluated once per completed 4-column scan:
  - IDLE: key seen -> CAND(code), cnt=1.
  - CAND: same code -> cnt+1; at cnt==DEBOUNCE_SCANS emit press(code) and go to HELD. Different code -> restart CAND with the new code. None -> IDLE.
  - HELD: none -> REL, cnt=1. Any key -> stay HELD (no repeat, no rollover).
  - REL: none -> cnt+1; at cnt==DEBOUNCE_SCANS go to IDLE. Any key -> HELD.
- Buttons: rising edges of btn_back and btn_submit are detected internally; one action per edge.
- Entry buffer, NUM_DIGITS nibbles; digit 0 is the rightmost (most recent):
  - press with count<NUM_DIGITS: shift left one nibble, insert code at digit 0, count+1.
  - press with count==NUM_DIGITS: ignored.
  - back with count>0: shift right one nibble, top nibble <- 0, count-1. With count==0: no-op.
  - submit with count==NUM_DIGITS: guess<=entry, guess_valid=1 for exactly one cycle (the next cycle), entry cleared, count=0. With count<NUM_DIGITS: no-op, no pulse.
  - Same-cycle priority: submit > back > press. The lower-priority event is dropped, not queued.
- Display:
  - Digit index d cycles 0..NUM_DIGITS-1 and wraps, advancing every REFRESH_DIV cycles.
  - an = ~(1<<d), hex_out = entry[4d+3:4d], blank = (d>=count).
  - Outputs are registered, so the anode and its data change on the same edge.
  - Buffer edits are visible from the next cycle.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2, REFRESH_DIV=8):
- Reset: hold rst 3 cycles -> col=1110, an=1110, count=0, blank=1, guess=0, guess_valid=0.
- Debounced press: hold row0 low during col1 for 3 full scans, then release for 3 scans -> exactly one press(2) after the 2nd scan, count=1, entry[3:0]=2. A 1-scan glitch -> no press.
- Fill, overflow, submit: press 1,2,3,4, then 5 -> count stays 4, entry=16'h1234. Rising edge on btn_submit -> guess=16'h1234 with one guess_valid pulse, then count=0 and entry=0.
- Backspace: enter 7,8, pulse back -> entry=16'h0007, count=1. Two more backs -> count=0; the second is a no-op.
- Early submit and priority: submit with count=3 -> no pulse, count=3. Press event coinciding with a back edge -> back applied, press dropped.
- Display mux: entry 16'h00A9, count=2 -> over 32 cycles, an steps 1110,1101,1011,0111; hex_out 9,A,0,0; blank 0,0,1,1. Assert reset mid-sequence -> all outputs return to reset values on the next edge.
